// File: rtl/montgomery_pkg.sv
// Shared types and elaboration-time helpers for the streaming Montgomery multiplier.
package montgomery_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FSUB = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest digit width the datapath supports (radix-4).
    localparam int DIGIT_BITS_MAX = 2;

    // Number of CALC iterations needed to consume the whole multiplicand.
    function automatic int n_iter(input int k_bits, input int digit_bits);
        return k_bits / digit_bits;
    endfunction

    // m' = -m^-1 mod 2^D for odd m. For D=2 an odd m is its own inverse mod 4,
    // so m' reduces to (4 - m) mod 4.
    function automatic logic [1:0] m_prime(input logic [1:0] m_low, input int digit_bits);
        if (digit_bits == 1) begin
            return 2'd1;
        end
        return 2'd0 - m_low;
    endfunction

    function automatic bit digit_bits_legal(input int digit_bits);
        return (digit_bits >= 1) && (digit_bits <= DIGIT_BITS_MAX);
    endfunction

endpackage

// File: rtl/montgomery_mmm_stream_digit_step.sv
// One Montgomery reduction step: consumes a DIGIT_BITS-wide digit of A and
// returns (P + a_i*B + q*m) / 2^D. Purely combinational so t and q stay visible.
module montgomery_digit_step
    import montgomery_pkg::*;
#(
    parameter int K_BITS     = 8,
    parameter int DIGIT_BITS = 1
) (
    input  logic [K_BITS:0]       i_P,
    input  logic [K_BITS-1:0]     i_B,
    input  logic [K_BITS-1:0]     i_m,
    input  logic [DIGIT_BITS-1:0] i_a,
    input  logic [DIGIT_BITS-1:0] i_mp,
    output logic [K_BITS:0]       o_P_next
);

    // P < 2m plus two digit-scaled K-bit terms always fits in K+3 bits.
    localparam int SW = K_BITS + 3;

    logic [SW-1:0]         w_ab;
    logic [SW-1:0]         w_t;
    logic [DIGIT_BITS-1:0] w_q;
    logic [SW-1:0]         w_qm;
    logic [SW-1:0]         w_u;

    // Shift-and-add products keep the digit multiplies tiny for D <= 2.
    always_comb begin
        w_ab = '0;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (i_a[j]) begin
                w_ab = w_ab + ({3'b000, i_B} << j);
            end
        end
        w_t = {2'b00, i_P} + w_ab;

        w_q = '0;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (i_mp[j]) begin
                w_q = w_q + (w_t[DIGIT_BITS-1:0] << j);
            end
        end

        w_qm = '0;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (w_q[j]) begin
                w_qm = w_qm + ({3'b000, i_m} << j);
            end
        end
        w_u = w_t + w_qm;
    end

    // Low D bits of w_u are zero by choice of q; the result is below 2m.
    assign o_P_next = w_u[K_BITS+DIGIT_BITS:DIGIT_BITS];

endmodule

// File: rtl/montgomery_mmm_stream.sv
// Streaming digit-serial Montgomery multiplier: P = A*B*2^-K mod m with
// valid/ready on both sides and an error qualifier for illegal operands.
module montgomery_mmm_stream
    import montgomery_pkg::*;
#(
    parameter int K_BITS     = 8,
    parameter int DIGIT_BITS = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [K_BITS-1:0] i_A,
    input  logic [K_BITS-1:0] i_B,
    input  logic [K_BITS-1:0] i_m,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [K_BITS-1:0] o_P,
    output logic              o_Err
);

    localparam int N  = n_iter(K_BITS, DIGIT_BITS);
    localparam int CW = $clog2(N + 1);

    if (!digit_bits_legal(DIGIT_BITS)) begin : g_bad_digit_bits
        $error("montgomery_mmm_stream: DIGIT_BITS must be 1 or 2");
    end
    if ((K_BITS < 2) || ((K_BITS % DIGIT_BITS) != 0)) begin : g_bad_k_bits
        $error("montgomery_mmm_stream: K_BITS must be >= 2 and a multiple of DIGIT_BITS");
    end

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [K_BITS-1:0]   r_p;
    logic                r_err;
    logic [CW-1:0]       r_cnt;
    logic [K_BITS:0]     r_preg;
    logic [K_BITS-1:0]   r_a;
    logic [K_BITS-1:0]   r_b;
    logic [K_BITS-1:0]   r_m;

    logic [1:0]            w_mp_full;
    logic [DIGIT_BITS-1:0] w_mp;
    logic [K_BITS:0]       w_p_next;
    logic [K_BITS+1:0]     w_diff;
    logic                  w_borrow;
    logic                  w_bad_ops;

    assign w_mp_full = m_prime(r_m[1:0], DIGIT_BITS);
    assign w_mp      = w_mp_full[DIGIT_BITS-1:0];
    assign w_diff    = {1'b0, r_preg} - {2'b00, r_m};
    assign w_borrow  = w_diff[K_BITS+1];
    assign w_bad_ops = !i_m[0] || (i_A >= i_m) || (i_B >= i_m);

    // r_a is shifted right each CALC cycle so the current digit is always at the bottom.
    montgomery_digit_step #(
        .K_BITS     (K_BITS),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_step (
        .i_P      (r_preg),
        .i_B      (r_b),
        .i_m      (r_m),
        .i_a      (r_a[DIGIT_BITS-1:0]),
        .i_mp     (w_mp),
        .o_P_next (w_p_next)
    );

    // Control FSM, iteration counter, operand latches and registered handshake outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_p     <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_preg  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_Valid && r_ready) begin
                        r_a     <= i_A;
                        r_b     <= i_B;
                        r_m     <= i_m;
                        r_preg  <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (w_bad_ops) begin
                            // Valid is raised from DONE one cycle later.
                            r_err   <= 1'b1;
                            r_p     <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_preg <= w_p_next;
                    r_a    <= r_a >> DIGIT_BITS;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= FSUB;
                    end
                end
                FSUB: begin
                    r_p     <= w_borrow ? r_preg[K_BITS-1:0] : w_diff[K_BITS-1:0];
                    r_err   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (i_Ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ready = r_ready;
    assign o_Valid = r_valid;
    assign o_P     = r_p;
    assign o_Err   = r_err;

endmodule

// File: tb/tb_montgomery_mmm_stream.sv
// Self-checking bench: four instances (K=8/16, D=1/2), directed vector table,
// backpressure and mid-calculation reset sequences, and a random scoreboard stream.
module tb_montgomery_mmm_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_v   = '0;
    logic [3:0]  in_rdy = '0;
    logic [15:0] in_a [4];
    logic [15:0] in_b [4];
    logic [15:0] in_m [4];
    logic [3:0]  o_rdy;
    logic [3:0]  o_v;
    logic [3:0]  o_err;
    logic [7:0]  p0, p1;
    logic [15:0] p2, p3;
    logic [15:0] p_all [4];

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sbq [$];

    always #5 clk = ~clk;

    always_comb begin
        p_all[0] = {8'h00, p0};
        p_all[1] = {8'h00, p1};
        p_all[2] = p2;
        p_all[3] = p3;
    end

    montgomery_mmm_stream #(.K_BITS(8), .DIGIT_BITS(1)) u_k8d1 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(in_v[0]), .o_Ready(o_rdy[0]),
        .i_A(in_a[0][7:0]), .i_B(in_b[0][7:0]), .i_m(in_m[0][7:0]),
        .o_Valid(o_v[0]), .i_Ready(in_rdy[0]), .o_P(p0), .o_Err(o_err[0]));
    montgomery_mmm_stream #(.K_BITS(8), .DIGIT_BITS(2)) u_k8d2 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(in_v[1]), .o_Ready(o_rdy[1]),
        .i_A(in_a[1][7:0]), .i_B(in_b[1][7:0]), .i_m(in_m[1][7:0]),
        .o_Valid(o_v[1]), .i_Ready(in_rdy[1]), .o_P(p1), .o_Err(o_err[1]));
    montgomery_mmm_stream #(.K_BITS(16), .DIGIT_BITS(1)) u_k16d1 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(in_v[2]), .o_Ready(o_rdy[2]),
        .i_A(in_a[2]), .i_B(in_b[2]), .i_m(in_m[2]),
        .o_Valid(o_v[2]), .i_Ready(in_rdy[2]), .o_P(p2), .o_Err(o_err[2]));
    montgomery_mmm_stream #(.K_BITS(16), .DIGIT_BITS(2)) u_k16d2 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(in_v[3]), .o_Ready(o_rdy[3]),
        .i_A(in_a[3]), .i_B(in_b[3]), .i_m(in_m[3]),
        .o_Valid(o_v[3]), .i_Ready(in_rdy[3]), .o_P(p3), .o_Err(o_err[3]));

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] m;
        logic [15:0] p;
        logic        err;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vt [$];

    // Reference: reduce A*B mod m, then halve mod m K times (x * 2^-1 mod m, m odd).
    function automatic logic [15:0] mont_ref(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] m, input int k);
        logic [63:0] x;
        x = ({48'd0, a} * {48'd0, b}) % {48'd0, m};
        for (int i = 0; i < k; i++) begin
            x = x[0] ? ((x + {48'd0, m}) >> 1) : (x >> 1);
        end
        return x[15:0];
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a triple, wait for o_Ready, return #1 after the accept edge with inputs scrambled.
    task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [15:0] m);
        int guard = 0;
        in_a[idx] = a;
        in_b[idx] = b;
        in_m[idx] = m;
        in_v[idx] = 1'b1;
        while (!o_rdy[idx] && guard < 200) begin
            step();
            guard++;
        end
        chk("accept ready", o_rdy[idx], 1);
        step();
        in_v[idx] = 1'b0;
        in_a[idx] = 16'($urandom);
        in_b[idx] = 16'($urandom);
        in_m[idx] = 16'($urandom);
    endtask

    task automatic wait_valid(input int idx, output int n);
        n = 0;
        while (!o_v[idx] && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        send(v.idx, v.a, v.b, v.m);
        wait_valid(v.idx, n);
        chk({v.nm, " latency"}, n, v.lat);
        chk({v.nm, " o_P"}, p_all[v.idx], v.p);
        chk({v.nm, " o_Err"}, o_err[v.idx], v.err);
        chk({v.nm, " o_Ready low in DONE"}, o_rdy[v.idx], 0);
        in_rdy[v.idx] = 1'b1;
        step();
        in_rdy[v.idx] = 1'b0;
        chk({v.nm, " o_Valid drop"}, o_v[v.idx], 0);
    endtask

    task automatic stream(input int idx, input int k, input int count);
        int got = 0;
        int cyc = 0;
        int budget;
        logic r;
        budget = count * (k + 40) + 1000;
        sbq.delete();
        fork
            begin
                int unsigned mm, aa, bb, mask;
                mask = (k == 8) ? 32'h00FF : 32'hFFFF;
                for (int n = 0; n < count; n++) begin
                    mm = ($urandom & mask) | 32'd1;
                    aa = $urandom % mm;
                    bb = $urandom % mm;
                    sbq.push_back(mont_ref(16'(aa), 16'(bb), 16'(mm), k));
                    send(idx, 16'(aa), 16'(bb), 16'(mm));
                    repeat ($urandom_range(0, 1)) step();
                end
            end
            begin
                while (got < count && cyc < budget) begin
                    r = 1'($urandom_range(0, 1));
                    in_rdy[idx] = r;
                    if (o_v[idx] && r) begin
                        chk("stream result expected", (sbq.size() != 0), 1);
                        if (sbq.size() != 0) begin
                            chk("stream o_P", p_all[idx], sbq.pop_front());
                        end
                        chk("stream o_Err", o_err[idx], 0);
                        got++;
                    end
                    step();
                    cyc++;
                end
                in_rdy[idx] = 1'b0;
            end
        join
        chk("stream result count", got, count);
        chk("stream leftover", sbq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 4; i++) begin
            in_a[i] = '0;
            in_b[i] = '0;
            in_m[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            chk("reset o_Ready", o_rdy[i], 1);
            chk("reset o_Valid", o_v[i], 0);
            chk("reset o_P", p_all[i], 0);
            chk("reset o_Err", o_err[i], 0);
        end

        vt.push_back('{0, 16'd5,   16'd7,   16'd13,  16'd1,   1'b0, 9,  "k8d1 5*7 m13"});
        vt.push_back('{1, 16'd5,   16'd7,   16'd13,  16'd1,   1'b0, 5,  "k8d2 5*7 m13"});
        vt.push_back('{0, 16'd200, 16'd150, 16'd251, 16'd227, 1'b0, 9,  "k8d1 200*150 m251"});
        vt.push_back('{1, 16'd200, 16'd150, 16'd251, 16'd227, 1'b0, 5,  "k8d2 200*150 m251"});
        vt.push_back('{0, 16'd254, 16'd254, 16'd255, mont_ref(16'd254, 16'd254, 16'd255, 8), 1'b0, 9, "k8d1 254*254 m255"});
        vt.push_back('{1, 16'd254, 16'd254, 16'd255, mont_ref(16'd254, 16'd254, 16'd255, 8), 1'b0, 5, "k8d2 254*254 m255"});
        vt.push_back('{0, 16'd0,   16'd0,   16'd1,   16'd0,   1'b0, 9,  "k8d1 m1"});
        vt.push_back('{0, 16'd3,   16'd4,   16'd12,  16'd0,   1'b1, 1,  "k8d1 even m"});
        vt.push_back('{1, 16'd3,   16'd4,   16'd12,  16'd0,   1'b1, 1,  "k8d2 even m"});
        vt.push_back('{0, 16'd13,  16'd0,   16'd13,  16'd0,   1'b1, 1,  "k8d1 A eq m"});
        vt.push_back('{1, 16'd2,   16'd20,  16'd13,  16'd0,   1'b1, 1,  "k8d2 B gt m"});
        vt.push_back('{2, 16'h1234, 16'h5678, 16'hFFF1, mont_ref(16'h1234, 16'h5678, 16'hFFF1, 16), 1'b0, 17, "k16d1"});
        vt.push_back('{3, 16'h1234, 16'h5678, 16'hFFF1, mont_ref(16'h1234, 16'h5678, 16'hFFF1, 16), 1'b0, 9,  "k16d2"});

        foreach (vt[i]) begin
            run_vec(vt[i]);
        end

        // Backpressure: result held 20 cycles while a new triple waits on the input.
        send(0, 16'd5, 16'd7, 16'd13);
        wait_valid(0, n);
        chk("bp first latency", n, 9);
        in_a[0] = 16'd200;
        in_b[0] = 16'd150;
        in_m[0] = 16'd251;
        in_v[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (o_v[0] !== 1'b1 || p_all[0] !== 16'd1 || o_rdy[0] !== 1'b0 || o_err[0] !== 1'b0) bad++;
        end
        chk("bp hold cycles disturbed", bad, 0);
        in_rdy[0] = 1'b1;
        step();
        in_rdy[0] = 1'b0;
        chk("bp o_Valid drop", o_v[0], 0);
        chk("bp o_Ready back", o_rdy[0], 1);
        step();
        in_v[0] = 1'b0;
        in_a[0] = 16'hFF;
        in_b[0] = 16'hFF;
        in_m[0] = 16'h02;
        chk("bp queued accepted", o_rdy[0], 0);
        wait_valid(0, n);
        chk("bp queued latency", n, 9);
        chk("bp queued o_P", p_all[0], 227);
        in_rdy[0] = 1'b1;
        step();
        in_rdy[0] = 1'b0;

        // Reset in the middle of CALC (counter = 3).
        send(0, 16'd5, 16'd7, 16'd13);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midreset o_Valid", o_v[0], 0);
        chk("midreset o_P", p_all[0], 0);
        chk("midreset o_Ready", o_rdy[0], 1);
        chk("midreset o_Err", o_err[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        run_vec('{0, 16'd5, 16'd7, 16'd13, 16'd1, 1'b0, 9, "post-reset 5*7 m13"});

        stream(0, 8, 250);
        stream(1, 8, 250);
        stream(2, 16, 250);
        stream(3, 16, 250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
